// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares the single write port of one fifo among REQS
//   producers. A grant lasts until the producer sends its last word, delivers BURST
//   words, or withdraws. Every grant is followed by exactly one idle cycle. Data is
//   forwarded combinationally from the granted producer and throttled by fifo_full.
//
// Ports
//   clk          clock, all state updates on rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    [REQS]        producer i presents a word
//   req_last     [REQS]        producer i's word ends its packet
//   req_data     [REQS*WIDTH]  producer i data at [i*WIDTH +: WIDTH]
//   req_ack      [REQS]        one-hot/zero, word of producer i accepted this cycle
//   fifo_d       [WIDTH]       to fifo.d_in
//   fifo_strobe                to fifo.d_in_strobe
//   fifo_full                  from fifo.full
//   grant_valid                a producer owns the write port
//   grant_id     [ID_W]        owning producer, 0 when grant_valid is low
module fifo_write_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REQS  = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQS-1:0]       req_valid,
    input  logic [REQS-1:0]       req_last,
    input  logic [REQS*WIDTH-1:0] req_data,
    output logic [REQS-1:0]       req_ack,
    output logic [WIDTH-1:0]      fifo_d,
    output logic                  fifo_strobe,
    input  logic                  fifo_full,
    output logic                  grant_valid,
    output logic [ID_W-1:0]       grant_id
);

    localparam int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        StIdle,
        StGrant
    } state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Signals of the currently granted producer
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             acc;

    // Round-robin search result
    logic             found;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  ptr_next;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < REQS; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign acc = (state_q == StGrant) && sel_valid && !fifo_full;

    // First requester at or after ptr_q, wrapping at REQS-1
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned k = 0; k < REQS; k++) begin
            idx = (32'(ptr_q) + k) % REQS;
            for (int unsigned i = 0; i < REQS; i++) begin
                if (!found && (i == idx) && req_valid[i]) begin
                    found = 1'b1;
                    pick  = ID_W'(i);
                end
            end
        end
    end

    assign ptr_next = (grant_q == ID_W'(REQS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                // Withdrawal, last word or full burst ends the grant
                if (!sel_valid || (acc && (sel_last || cnt_q == CNT_W'(BURST - 1)))) begin
                    state_d = StIdle;
                    ptr_d   = ptr_next;
                end else begin
                    cnt_d = cnt_q + CNT_W'(acc);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        req_ack     = '0;
        grant_valid = (state_q == StGrant);
        grant_id    = grant_valid ? grant_q : '0;
        fifo_d      = grant_valid ? sel_data : '0;
        fifo_strobe = acc;
        for (int unsigned i = 0; i < REQS; i++) begin
            if (grant_q == ID_W'(i)) req_ack[i] = acc;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

    localparam int WIDTH = 4;
    localparam int REQS  = 4;
    localparam int ID_W  = 2;
    localparam int BURST = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [REQS-1:0]       req_valid;
    logic [REQS-1:0]       req_last;
    logic [REQS*WIDTH-1:0] req_data;
    logic [REQS-1:0]       req_ack;
    logic [WIDTH-1:0]      fifo_d;
    logic                  fifo_strobe;
    logic                  fifo_full;
    logic                  grant_valid;
    logic [ID_W-1:0]       grant_id;

    fifo_write_arbiter #(
        .WIDTH(WIDTH),
        .REQS (REQS),
        .ID_W (ID_W),
        .BURST(BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .fifo_d     (fifo_d),
        .fifo_strobe(fifo_strobe),
        .fifo_full  (fifo_full),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Producers: rem = words left in current packet, pd = word on offer
    int             rem[REQS];
    logic [WIDTH-1:0] pd[REQS];

    // Reference model: owner (-1 = nobody), rotation pointer, words in this grant
    int owner;
    int ptr;
    int words;

    // Observed grant history from the DUT
    int  dut_log[$];
    int  ack_log[$];
    int  exp_g[$];
    int  exp_a[$];
    int  cur_acks;
    bit  prev_gv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < REQS; i++) begin
            req_valid[i]              = (rem[i] > 0);
            req_last[i]               = (rem[i] == 1);
            req_data[i*WIDTH +: WIDTH] = pd[i];
        end
    endtask

    task automatic clear_logs();
        dut_log.delete();
        ack_log.delete();
        cur_acks = 0;
        prev_gv  = 1'b0;
    endtask

    task automatic chk_logs(input string tag);
        chk({tag, "_ngrants"}, dut_log.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < dut_log.size(); i++)
            chk({tag, "_grant"}, dut_log[i], exp_g[i]);
        chk({tag, "_nacks"}, ack_log.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < ack_log.size(); i++)
            chk({tag, "_acks"}, ack_log[i], exp_a[i]);
    endtask

    // One clock cycle: check outputs at negedge, advance model, advance producers
    task automatic step();
        logic [REQS-1:0]  e_ack;
        logic             e_strobe;
        logic             e_gv;
        logic [ID_W-1:0]  e_gid;
        logic [WIDTH-1:0] e_d;
        bit               acc;
        int               ap;
        int               nxt;
        @(negedge clk);
        e_ack = '0; e_strobe = 1'b0; e_gv = 1'b0; e_gid = '0; e_d = '0; acc = 1'b0; ap = -1;
        if (owner >= 0) begin
            acc          = (rem[owner] > 0) && !fifo_full;
            e_gv         = 1'b1;
            e_gid        = ID_W'(owner);
            e_d          = pd[owner];
            e_strobe     = acc;
            e_ack[owner] = acc;
            if (acc) ap = owner;
        end
        chk("req_ack", 32'(req_ack), 32'(e_ack));
        chk("fifo_strobe", 32'(fifo_strobe), 32'(e_strobe));
        chk("grant_valid", 32'(grant_valid), 32'(e_gv));
        chk("grant_id", 32'(grant_id), 32'(e_gid));
        chk("fifo_d", 32'(fifo_d), 32'(e_d));

        if (grant_valid && !prev_gv) begin
            dut_log.push_back(int'(grant_id));
            cur_acks = 0;
        end
        if (grant_valid && req_ack != '0) cur_acks++;
        if (!grant_valid && prev_gv) ack_log.push_back(cur_acks);
        prev_gv = grant_valid;

        if (owner < 0) begin
            nxt = -1;
            for (int k = 0; k < REQS; k++)
                if (nxt < 0 && rem[(ptr + k) % REQS] > 0) nxt = (ptr + k) % REQS;
            owner = nxt;
            words = 0;
        end else if (rem[owner] == 0 || (acc && (rem[owner] == 1 || words == BURST - 1))) begin
            ptr   = (owner + 1) % REQS;
            owner = -1;
        end else begin
            words += int'(acc);
        end

        @(posedge clk);
        #1;
        if (ap >= 0) begin
            rem[ap]--;
            pd[ap] = WIDTH'($urandom);
        end
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        owner     = -1;
        ptr       = 0;
        words     = 0;
        for (int i = 0; i < REQS; i++) begin
            rem[i] = 0;
            pd[i]  = WIDTH'($urandom);
        end
        clear_logs();

        // Reset state, then single producer 2 with a 3-word packet
        rem[2] = 3;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_strobe", 32'(fifo_strobe), 0);
        chk("rst_gv", 32'(grant_valid), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_fifo_d", 32'(fifo_d), 0);
        rst_n = 1'b1;
        run(6);
        exp_g = '{2};
        exp_a = '{3};
        chk_logs("single");

        // Wrap-around: pointer now 3, only producers 0 and 2 request
        clear_logs();
        rem[0] = 2;
        rem[2] = 2;
        drive();
        run(8);
        exp_g = '{0, 2};
        exp_a = '{2, 2};
        chk_logs("wrap");

        // Stall: fifo_full for 3 cycles in the middle of producer 1's burst
        clear_logs();
        rem[1] = 100;
        drive();
        run(3);
        fifo_full = 1'b1;
        run(3);
        fifo_full = 1'b0;
        run(2);
        rem[1] = 0;
        drive();
        run(2);
        exp_g = '{1};
        exp_a = '{4};
        chk_logs("stall");

        // Async reset while producer 2 has a word on the bus
        rem[2] = 3;
        drive();
        run(2);
        #2;
        chk("pre_rst_strobe", 32'(fifo_strobe), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_strobe", 32'(fifo_strobe), 0);
        chk("arst_gv", 32'(grant_valid), 0);
        chk("arst_ack", 32'(req_ack), 0);
        chk("arst_gid", 32'(grant_id), 0);
        rem[2] = 0;
        drive();
        owner = -1;
        ptr   = 0;
        words = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four request continuously, never last
        clear_logs();
        for (int i = 0; i < REQS; i++) rem[i] = 1000;
        drive();
        run(20);
        for (int i = 0; i < REQS; i++) rem[i] = 0;
        drive();
        run(2);
        exp_g = '{0, 1, 2, 3};
        exp_a = '{4, 4, 4, 4};
        chk_logs("rr");

        // Producer 1 withdraws after one word, producer 3 also requesting
        clear_logs();
        rem[1] = 50;
        rem[3] = 50;
        drive();
        run(2);
        rem[1] = 0;
        drive();
        run(6);
        rem[3] = 0;
        drive();
        run(2);
        exp_g = '{1, 3};
        exp_a = '{1, 4};
        chk_logs("withdraw");

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < REQS; i++) begin
                if (rem[i] == 0 && $urandom_range(3) == 0) rem[i] = int'($urandom_range(6, 1));
                else if (rem[i] > 0 && $urandom_range(40) == 0) rem[i] = 0;
            end
            fifo_full = ($urandom_range(3) == 0);
            drive();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares the single write port of one `fifo` instance between `REQS` independent producers. A grant is held for a bounded burst. Data is forwarded combinationally from the granted producer to the FIFO's `d_in`/`d_in_strobe`, throttled by the FIFO's `full` flag. The block sits directly in front of the FIFO's write side. The read side is untouched.

## Interface
Parameters:
- `WIDTH`, 4, data word width; must match the downstream `fifo` `WIDTH`.
- `REQS`, 4, number of producers; 2 ≤ `REQS` ≤ 2^`ID_W`.
- `ID_W`, 2, width of the grant index.
- `BURST`, 4, maximum words accepted per grant; ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `REQS`  producer i has a word on its data slice.
- `req_last`  in  `REQS`  the word of producer i is the last of its packet.
- `req_data`  in  `REQS*WIDTH`  producer i data at bits `[i*WIDTH +: WIDTH]`.
- `req_ack`  out  `REQS`  one-hot or zero; word of producer i accepted this cycle.
- `fifo_d`  out  `WIDTH`  to `fifo.d_in`.
- `fifo_strobe`  out  1  to `fifo.d_in_strobe`.
- `fifo_full`  in  1  from `fifo.full`.
- `grant_valid`  out  1  a producer currently owns the write port.
- `grant_id`  out  `ID_W`  index of the owning producer; 0 when `grant_valid` = 0.

## Operation
- There are two states, IDLE and GRANT. The registered state is `state`, `grant_id`, `ptr` (round-robin pointer, `ID_W` bits) and `cnt` (burst count, 0..`BURST`-1).
- **IDLE**
  - `req_ack` = 0 and `fifo_strobe` = 0.
  - If any `req_valid` is set, select the first i with `req_valid[i]`, searching from `ptr` upward and wrapping at `REQS`-1 → 0.
  - Next state is GRANT with `grant_id` <= i and `cnt` <= 0.
  - If no request is present, remain in IDLE.
- **GRANT**, with g = `grant_id`:
  - Accept condition: `acc` = `req_valid[g]` & ~`fifo_full`.
  - `fifo_strobe` = `acc`, `req_ack[g]` = `acc`, and all other acks = 0.
  - `fifo_d` = slice g of `req_data` whenever `grant_valid` is high; otherwise `fifo_d` = 0.
- **Leaving GRANT** for IDLE, with `ptr` <= (g+1) mod `REQS`:
  - (a) `acc` & `req_last[g]`, or
  - (b) `acc` & (`cnt` == `BURST`-1), or
  - (c) ~`req_valid[g]` (the producer withdrew; nothing is transferred that cycle).
- **Otherwise** remain in GRANT, with `cnt` <= `cnt` + `acc`.
- **`fifo_full` high in GRANT**: stall with no strobe, no ack and no timeout. The grant is kept while `req_valid[g]` stays high.
- Producers must hold `req_valid`, `req_data` and `req_last` stable until acked. Dropping `req_valid` without an ack ends the grant.
- `grant_valid` = (state == GRANT).
- The block never drives `fifo_strobe` while `fifo_full` is high, so the FIFO never overwrites.

## Timing
- Reset (`rst_n` low, asynchronous, any time including mid-burst):
  - state = IDLE, `ptr` = 0, `cnt` = 0, `grant_id` = 0.
  - All outputs are 0: `req_ack`, `fifo_strobe`, `fifo_d`, `grant_valid`, `grant_id`.
  - A word in flight is neither acked nor written.
- Arbitration latency: a request seen in IDLE at edge N is granted after edge N. The first word can transfer in the cycle following edge N, i.e. one cycle after the request.
- The ack is combinational in the same cycle as `fifo_strobe`. The producer advances its data on the next edge.
- Every grant is followed by exactly one IDLE cycle. Peak throughput is `BURST` words per `BURST`+1 cycles.
- Fairness: a continuously requesting producer waits at most (`REQS`-1) grants, each at most `BURST` accepted words plus stall time.
- Simultaneous requests in IDLE are resolved by `ptr` order only. `req_last` is ignored unless `acc` is set.

## Test plan
- **Reset and single producer.** Release reset with producer 2 valid, `last` on its third word, FIFO not full.
  - Expected: grant to 2 one cycle after the request, three consecutive strobes carrying its words, back to IDLE, `ptr` = 3.
- **All four requesting continuously, `BURST` = 4, no `last`.**
  - Expected: grants in order 0,1,2,3,0…, exactly 4 acks per grant, one idle cycle between grants.
- **`fifo_full` asserted for 3 cycles mid-burst.**
  - Expected: no strobe or ack during those 3 cycles, grant held, remaining words delivered afterward, and `cnt` not advanced while stalled.
- **Producer 1 drops `req_valid` after one word while producers 1 and 3 request.**
  - Expected: grant ends without a strobe that cycle, `ptr` = 2, next grant goes to 3.
- **Async reset mid-burst.** Assert `rst_n` low between edges.
  - Expected: `fifo_strobe` and `grant_valid` fall immediately; after release the first grant goes to the lowest-indexed requester (`ptr` = 0).
- **Wrap-around.** `ptr` = 3, only producers 0 and 2 requesting.
  - Expected: grant to 0, then 2.
